// File: rtl/mem_store_unit_pkg.sv
// Shared store-unit definitions: store op encodings, FSM state encoding and byte-merge helper.
package mem_store_unit_pkg;

    localparam logic [1:0] STOP_SB = 2'b00;
    localparam logic [1:0] STOP_SH = 2'b01;
    localparam logic [1:0] STOP_SW = 2'b10;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StRead  = 2'b01,
        StWrite = 2'b10,
        StDone  = 2'b11
    } state_e;

    // Bytes of new_data replace old_data wherever the matching enable is set.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_data,
                                                input logic [31:0] new_data,
                                                input logic [3:0]  be);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) begin
            m[8*i +: 8] = be[i] ? new_data[8*i +: 8] : old_data[8*i +: 8];
        end
        return m;
    endfunction

endpackage

// File: rtl/store_align.sv
// Combinational lane logic for stores: byte enables, replicated write data,
// misalignment detection and read-merge for the RMW path.
module store_align
    import mem_store_unit_pkg::*;
(
    input  logic [1:0]  op_i,
    input  logic [1:0]  lane_i,
    input  logic [31:0] data_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic        misalign_o,
    output logic [31:0] merged_o
);

    always_comb begin
        be_o       = 4'b0000;
        wdata_o    = data_i;
        misalign_o = 1'b0;
        case (op_i)
            STOP_SB: begin
                be_o    = 4'b0001 << lane_i;
                wdata_o = {4{data_i[7:0]}};
            end
            STOP_SH: begin
                be_o       = 4'b0011 << lane_i;
                wdata_o    = {2{data_i[15:0]}};
                misalign_o = lane_i[0];
            end
            STOP_SW: begin
                be_o       = 4'b1111;
                misalign_o = |lane_i;
            end
            // Unused encoding is refused without touching memory.
            default: misalign_o = 1'b1;
        endcase
    end

    assign merged_o = merge_bytes(rdata_i, wdata_i, be_i);

endmodule

// File: rtl/mem_store_unit.sv
// MEM-stage store unit: drives SB/SH/SW stores onto a 32-bit word bus with ack timeout.
// Define STORE_RMW_EN for memories without byte enables (read, merge, then full-word write).
module mem_store_unit
    import mem_store_unit_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        st_valid,
    input  logic [1:0]  st_op,
    input  logic [31:0] st_addr,
    input  logic [31:0] st_data,
    output logic        st_done,
    output logic        stall,
    output logic        misalign,
    output logic        timeout,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam int unsigned     CntW    = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(ACK_TIMEOUT - 1);

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [29:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [3:0]      be_q, be_d;
    logic            misalign_q, misalign_d;
    logic            timeout_q, timeout_d;

    logic [3:0]  al_be;
    logic [31:0] al_wdata;
    logic        al_misalign;
    logic [31:0] al_merged;
    logic        busy;

    store_align u_store_align (
        .op_i       (st_op),
        .lane_i     (st_addr[1:0]),
        .data_i     (st_data),
        .be_i       (be_q),
        .wdata_i    (wdata_q),
        .rdata_i    (mem_rdata),
        .be_o       (al_be),
        .wdata_o    (al_wdata),
        .misalign_o (al_misalign),
        .merged_o   (al_merged)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        misalign_d = misalign_q;
        timeout_d  = timeout_q;
        unique case (state_q)
            StIdle: begin
                if (st_valid) begin
                    addr_d     = st_addr[31:2];
                    wdata_d    = al_wdata;
                    be_d       = al_be;
                    misalign_d = al_misalign;
                    timeout_d  = 1'b0;
                    cnt_d      = '0;
                    if (al_misalign) begin
                        state_d = StDone;
                    end else begin
`ifdef STORE_RMW_EN
                        state_d = StRead;
`else
                        state_d = StWrite;
`endif
                    end
                end
            end
            StRead: begin
`ifdef STORE_RMW_EN
                if (mem_ack) begin
                    wdata_d = al_merged;
                    cnt_d   = '0;
                    state_d = StWrite;
                end else if (cnt_q == LastCnt) begin
                    timeout_d = 1'b1;
                    state_d   = StDone;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
`else
                state_d = StIdle;
`endif
            end
            StWrite: begin
                // An ack in the final wait cycle still completes the store.
                if (mem_ack) begin
                    state_d = StDone;
                end else if (cnt_q == LastCnt) begin
                    timeout_d = 1'b1;
                    state_d   = StDone;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDone: begin
                misalign_d = 1'b0;
                timeout_d  = 1'b0;
                state_d    = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            misalign_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            be_q       <= be_d;
            misalign_q <= misalign_d;
            timeout_q  <= timeout_d;
        end
    end

    assign busy      = (state_q == StRead) || (state_q == StWrite);
    assign mem_req   = busy;
    assign mem_we    = (state_q == StWrite);
    assign mem_addr  = busy ? {addr_q, 2'b00} : 32'h0;
    assign mem_wdata = busy ? wdata_q : 32'h0;
`ifdef STORE_RMW_EN
    assign mem_be    = busy ? 4'b1111 : 4'b0000;
`else
    assign mem_be    = busy ? be_q : 4'b0000;
    logic unused_merged;
    assign unused_merged = ^al_merged;
`endif

    assign st_done  = (state_q == StDone);
    assign misalign = st_done & misalign_q;
    assign timeout  = st_done & timeout_q;
    assign stall    = st_valid & ~st_done;

endmodule
